// File: rtl/conv2_pool_reader_pkg.sv
// Shared constants, FSM encoding and address helper for the layer-2 pooling reader.
// Optional feature macro used by this slice: POOL2_AVG_EN (average instead of max pooling).
package conv2_pool_reader_pkg;

  localparam int CONV2_COLS      = 24;
  localparam int CONV2_BANK_SIZE = 48;
  localparam int POOL2_OUT_NUM   = 12;
  localparam int POOL2_READS     = 4 * POOL2_OUT_NUM;
  localparam int CONV2_ADDR_W    = 7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Read k = 4w + j: j[1] selects the row, j[0] the column inside window w.
  function automatic logic [CONV2_ADDR_W-1:0] pool2_addr(input logic bank, input logic [5:0] k);
    logic [CONV2_ADDR_W-1:0] a;
    a = bank ? CONV2_ADDR_W'(CONV2_BANK_SIZE) : '0;
    if (k[1]) a = a + CONV2_ADDR_W'(CONV2_COLS);
    a = a + {2'b00, k[5:2], k[0]};
    return a;
  endfunction

endpackage

// File: rtl/conv2_pool_reader_window_acc.sv
// pool2_window_acc: 4-sample max (or, with POOL2_AVG_EN, average) accumulator.
// i_load starts a window, i_acc folds in a sample, i_last also registers the result.
module pool2_window_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_acc,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

`ifdef POOL2_AVG_EN
  localparam int ACC_W = DATA_W + 2;
`else
  localparam int ACC_W = DATA_W;
`endif

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_next;
  logic [ACC_W-1:0]  w_data_ext;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_comb begin
    w_data_ext = ACC_W'(i_data);
    w_next     = r_acc;
    if (i_load) begin
      w_next = w_data_ext;
    end else if (i_acc) begin
`ifdef POOL2_AVG_EN
      w_next = r_acc + w_data_ext;
`else
      if (w_data_ext > r_acc) w_next = w_data_ext;
`endif
    end
  end

  // The top slice of the accumulator is the max itself, or the sum divided by 4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_acc   <= w_next;
      r_valid <= i_last;
      if (i_last) r_data <= w_next[ACC_W-1:ACC_W-DATA_W];
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/conv2_pool_reader.sv
// Layer-2 line-buffer read side: walks one bank in 2x2 windows and streams 12 pooled bytes.
// Build option POOL2_AVG_EN switches the window accumulator to average pooling.
module conv2_pool_reader
  import conv2_pool_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = CONV2_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bank,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              done
);

  state_t            r_state;
  logic              r_bank;
  logic [5:0]        r_k;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_pv;
  logic [5:0]        r_pk;
  logic [3:0]        r_out_idx;
  logic              r_done;
  logic              w_load;
  logic              w_acc;
  logic              w_last;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;

  // r_pv/r_pk tag the rd_data arriving this cycle with the read that produced it.
  assign w_load = r_pv && (r_pk[1:0] == 2'd0);
  assign w_acc  = r_pv && (r_pk[1:0] != 2'd0);
  assign w_last = r_pv && (r_pk[1:0] == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_bank    <= 1'b0;
      r_k       <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_pv      <= 1'b0;
      r_pk      <= '0;
      r_out_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_pv   <= r_rd_en;
      r_pk   <= r_k;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !r_done) begin
            r_bank    <= bank;
            r_k       <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(pool2_addr(bank, 6'd0));
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (r_k == 6'(POOL2_READS - 1)) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_k       <= r_k + 6'd1;
            r_rd_addr <= ADDR_W'(pool2_addr(r_bank, r_k + 6'd1));
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_last) r_out_idx <= r_pk[5:2];
    end
  end

  pool2_window_acc #(.DATA_W(DATA_W)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_acc  (w_acc),
    .i_last (w_last),
    .i_data (rd_data),
    .o_valid(w_out_valid),
    .o_data (w_out_data)
  );

  assign busy      = (r_state != ST_IDLE);
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign out_idx   = r_out_idx;
  assign done      = r_done;

endmodule

// File: tb/tb_conv2_pool_reader.sv
// Scoreboard bench for conv2_pool_reader with a behavioural line-buffer model.
module tb_conv2_pool_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bank = 1'b0;
  logic       busy, rd_en, out_valid, done;
  logic [6:0] rd_addr;
  logic [7:0] rd_data, out_data;
  logic [3:0] out_idx;

  always #5 clk = ~clk;

  conv2_pool_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bank     (bank),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_idx  (out_idx),
    .done     (done)
  );

  // Line buffer: registered read, zero when not enabled.
  logic [7:0] mem [0:95];
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= 8'd0;
    else      rd_data <= rd_en ? mem[rd_addr] : 8'd0;
  end

  typedef struct {int idx; int val; int rel;} exp_t;
  exp_t outQ[$];
  int   addrQ[$];

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int startEdge = 0;
  int doneCount = 0;
  int monRel;
  bit active = 1'b0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected addresses and pooled values derived from the window geometry.
  task automatic refModel(input bit b);
    for (int w = 0; w < 12; w++) begin
      int mx, sum, v;
      mx = 0;
      sum = 0;
      for (int j = 0; j < 4; j++) begin
        int a;
        a = b * 48 + (j / 2) * 24 + 2 * w + (j % 2);
        addrQ.push_back(a);
        v = mem[a];
        sum += v;
        if (v > mx) mx = v;
      end
`ifdef POOL2_AVG_EN
      outQ.push_back('{w, sum / 4, 4 * w + 5});
`else
      outQ.push_back('{w, mx, 4 * w + 5});
`endif
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or a strobe.
  always @(negedge clk) begin
    if (rst) begin
      monRel = cyc - startEdge;
      if (rd_en) begin
        if (!active || addrQ.size() == 0) checkOutput("spurious_rd_en", 1, 0);
        else checkOutput("rd_addr", int'(rd_addr), addrQ.pop_front());
      end
      if (out_valid) begin
        if (!active || outQ.size() == 0) checkOutput("spurious_out_valid", 1, 0);
        else begin
          exp_t e;
          e = outQ.pop_front();
          checkOutput("out_data", int'(out_data), e.val);
          checkOutput("out_idx", int'(out_idx), e.idx);
          checkOutput("strobe_cycle", monRel, e.rel);
        end
      end
      if (done) begin
        doneCount++;
        if (!active) checkOutput("spurious_done", 1, 0);
        else begin
          checkOutput("done_cycle", monRel, 50);
          checkOutput("busy_at_done", int'(busy), 0);
        end
      end
      if (active && monRel <= 49) checkOutput("busy_high", int'(busy), 1);
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_rd_en"}, int'(rd_en), 0);
    checkOutput({tag, "_rd_addr"}, int'(rd_addr), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_data"}, int'(out_data), 0);
    checkOutput({tag, "_out_idx"}, int'(out_idx), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  task automatic applyStimulus(input bit b, input bit extraStart, input int abortAt);
    int doneBase, rel;
    doneBase = doneCount;
    refModel(b);
    @(negedge clk);
    start = 1'b1;
    bank = b;
    @(posedge clk);
    #1;
    startEdge = cyc;
    active = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      rel = cyc - startEdge;
      if (extraStart) begin
        start = (rel == 10);
        bank = (rel == 10) ? ~b : b;
      end
      if (abortAt == rel) begin
        rst = 1'b0;
        #1;
        checkAllZero("abort");
        outQ.delete();
        addrQ.delete();
        active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("no_done_after_abort", doneCount - doneBase, 0);
        return;
      end
      if (doneCount != doneBase) break;
    end
    start = 1'b0;
    checkOutput("done_seen", doneCount - doneBase, 1);
    start = 1'b1;
    bank = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_at_done_busy", int'(busy), 0);
    checkOutput("start_at_done_rd_en", int'(rd_en), 0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("single_done", doneCount - doneBase, 1);
    checkOutput("out_queue_drained", outQ.size(), 0);
    checkOutput("addr_queue_drained", addrQ.size(), 0);
  endtask

  task automatic fillRandom();
    for (int a = 0; a < 96; a++) mem[a] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    for (int a = 0; a < 96; a++) mem[a] = 8'(a + 1);
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b1;

    $display("[TB] ramp data, bank 0");
    applyStimulus(1'b0, 1'b0, -1);
    $display("[TB] ramp data, bank 1");
    applyStimulus(1'b1, 1'b0, -1);

    $display("[TB] max position independence");
    fillRandom();
    mem[0] = 8'd200; mem[1] = 8'd3; mem[24] = 8'd7; mem[25] = 8'd9;
    mem[2] = 8'd1;   mem[3] = 8'd2; mem[26] = 8'd3; mem[27] = 8'd250;
    mem[4] = 8'd1;   mem[5] = 8'd2; mem[28] = 8'd3; mem[29] = 8'd5;
    mem[6] = 8'd255; mem[7] = 8'd255; mem[30] = 8'd255; mem[31] = 8'd255;
    mem[8] = 8'd0;   mem[9] = 8'd0; mem[32] = 8'd0; mem[33] = 8'd0;
    applyStimulus(1'b0, 1'b0, -1);

    $display("[TB] start while busy");
    fillRandom();
    applyStimulus(1'b0, 1'b1, -1);

    $display("[TB] async reset mid-operation");
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, -1);

    $display("[TB] random banks");
    for (int n = 0; n < 3; n++) begin
      fillRandom();
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
